// File: rtl/conv_transpose2d.sv
// Transposed 2-D convolution (learned upsampling) over a CHW int8 feature map.
// Each output pixel gathers its contributing input taps from an external
// single-port input memory, one MAC per tap, then writes a saturated int8
// result to an external output memory.
module conv_transpose2d #(
    parameter int IN_CHANNELS    = 2,
    parameter int OUT_CHANNELS   = 2,
    parameter int IN_HEIGHT      = 4,
    parameter int IN_WIDTH       = 4,
    parameter int KERNEL_SIZE    = 3,
    parameter int STRIDE         = 2,
    parameter int PADDING        = 1,
    parameter int OUTPUT_PADDING = 1,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int ACC_WIDTH      = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         done,
    output logic                         valid,
    output logic [ADDR_WIDTH-1:0]        input_addr,
    output logic                         input_en,
    input  logic signed [DATA_WIDTH-1:0] input_data,
    output logic [ADDR_WIDTH-1:0]        output_addr,
    output logic signed [DATA_WIDTH-1:0] output_data,
    output logic                         output_we,
    output logic                         output_en
);
    localparam int OUT_H = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE + OUTPUT_PADDING;
    localparam int OUT_W = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE + OUTPUT_PADDING;
    localparam int IC_W  = (IN_CHANNELS  > 1) ? $clog2(IN_CHANNELS)  : 1;
    localparam int OC_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int K_W   = (KERNEL_SIZE  > 1) ? $clog2(KERNEL_SIZE)  : 1;
    localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int PW    = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ISSUE, S_ACC, S_STORE, S_WRITE, S_DONE
    } state_t;

    state_t                       state_reg;
    logic [OC_W-1:0]              oc_reg;
    logic [OY_W-1:0]              oy_reg;
    logic [OX_W-1:0]              ox_reg;
    logic [IC_W-1:0]              ic_reg;
    logic [K_W-1:0]               ky_reg;
    logic [K_W-1:0]               kx_reg;
    logic signed [ACC_WIDTH-1:0]  acc_reg;
    logic                         tap_valid_reg;

    logic signed [DATA_WIDTH-1:0] weights [IN_CHANNELS][OUT_CHANNELS][KERNEL_SIZE][KERNEL_SIZE];
    logic signed [DATA_WIDTH-1:0] bias [OUT_CHANNELS];

    logic [IC_W-1:0]              ic_next;
    logic [K_W-1:0]               ky_next;
    logic [K_W-1:0]               kx_next;
    logic                         last_tap;
    logic [IC_W-1:0]              ic_sel;
    logic [K_W-1:0]               ky_sel;
    logic [K_W-1:0]               kx_sel;
    logic                         tap_valid;
    logic [ADDR_WIDTH-1:0]        tap_addr;
    logic [ADDR_WIDTH-1:0]        out_addr;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  tap_term;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic                         last_out;
    int                           ny;
    int                           nx;

    // Coefficient store: fixed at +1 weights and zero bias after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < IN_CHANNELS; a++)
                for (int b = 0; b < OUT_CHANNELS; b++)
                    for (int y = 0; y < KERNEL_SIZE; y++)
                        for (int x = 0; x < KERNEL_SIZE; x++)
                            weights[a][b][y][x] <= DATA_WIDTH'(1);
            for (int b = 0; b < OUT_CHANNELS; b++)
                bias[b] <= '0;
        end
    end

    // Next tap indices (kx fastest, then ky, then ic) and the last-tap flag.
    always_comb begin
        kx_next  = kx_reg + 1'b1;
        ky_next  = ky_reg;
        ic_next  = ic_reg;
        last_tap = 1'b0;
        if (int'(kx_reg) == KERNEL_SIZE - 1) begin
            kx_next = '0;
            if (int'(ky_reg) == KERNEL_SIZE - 1) begin
                ky_next = '0;
                if (int'(ic_reg) == IN_CHANNELS - 1) begin
                    ic_next  = '0;
                    last_tap = 1'b1;
                end else begin
                    ic_next = ic_reg + 1'b1;
                end
            end else begin
                ky_next = ky_reg + 1'b1;
            end
        end
    end

    // Tap about to be issued: the first tap from INIT, otherwise the following one.
    // The read is launched on entry to ISSUE so data returns during ACC.
    always_comb begin
        ic_sel    = (state_reg == S_INIT) ? '0 : ic_next;
        ky_sel    = (state_reg == S_INIT) ? '0 : ky_next;
        kx_sel    = (state_reg == S_INIT) ? '0 : kx_next;
        ny        = int'(oy_reg) + PADDING - int'(ky_sel);
        nx        = int'(ox_reg) + PADDING - int'(kx_sel);
        tap_valid = (ny >= 0) && (ny % STRIDE == 0) && (ny / STRIDE < IN_HEIGHT) &&
                    (nx >= 0) && (nx % STRIDE == 0) && (nx / STRIDE < IN_WIDTH);
        tap_addr  = '0;
        if (tap_valid)
            tap_addr = ADDR_WIDTH'(int'(ic_sel) * IN_HEIGHT * IN_WIDTH +
                                   (ny / STRIDE) * IN_WIDTH + (nx / STRIDE));
    end

    // MAC datapath terms and output addressing.
    always_comb begin
        prod     = input_data * weights[ic_reg][oc_reg][ky_reg][kx_reg];
        tap_term = tap_valid_reg ? {{(ACC_WIDTH - PW){prod[PW-1]}}, prod} : '0;
        bias_ext = {{(ACC_WIDTH - DATA_WIDTH){bias[oc_reg][DATA_WIDTH-1]}}, bias[oc_reg]};
        out_addr = ADDR_WIDTH'(int'(oc_reg) * OUT_H * OUT_W + int'(oy_reg) * OUT_W + int'(ox_reg));
        last_out = (int'(ox_reg) == OUT_W - 1) && (int'(oy_reg) == OUT_H - 1) &&
                   (int'(oc_reg) == OUT_CHANNELS - 1);
    end

    // Control FSM with registered memory-master and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            oc_reg        <= '0;
            oy_reg        <= '0;
            ox_reg        <= '0;
            ic_reg        <= '0;
            ky_reg        <= '0;
            kx_reg        <= '0;
            acc_reg       <= '0;
            tap_valid_reg <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            input_addr    <= '0;
            input_en      <= 1'b0;
            output_addr   <= '0;
            output_data   <= '0;
            output_we     <= 1'b0;
            output_en     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        oc_reg    <= '0;
                        oy_reg    <= '0;
                        ox_reg    <= '0;
                        state_reg <= S_INIT;
                    end
                end
                S_INIT: begin
                    acc_reg       <= bias_ext;
                    ic_reg        <= '0;
                    ky_reg        <= '0;
                    kx_reg        <= '0;
                    input_en      <= tap_valid;
                    tap_valid_reg <= tap_valid;
                    if (tap_valid)
                        input_addr <= tap_addr;
                    state_reg     <= S_ISSUE;
                end
                S_ISSUE: begin
                    input_en  <= 1'b0;
                    state_reg <= S_ACC;
                end
                S_ACC: begin
                    acc_reg <= acc_reg + tap_term;
                    if (last_tap) begin
                        state_reg <= S_STORE;
                    end else begin
                        ic_reg        <= ic_next;
                        ky_reg        <= ky_next;
                        kx_reg        <= kx_next;
                        input_en      <= tap_valid;
                        tap_valid_reg <= tap_valid;
                        if (tap_valid)
                            input_addr <= tap_addr;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_STORE: begin
                    if (acc_reg > SAT_HI)
                        output_data <= {1'b0, {(DATA_WIDTH - 1){1'b1}}};
                    else if (acc_reg < SAT_LO)
                        output_data <= {1'b1, {(DATA_WIDTH - 1){1'b0}}};
                    else
                        output_data <= acc_reg[DATA_WIDTH-1:0];
                    output_addr <= out_addr;
                    output_we   <= 1'b1;
                    output_en   <= 1'b1;
                    state_reg   <= S_WRITE;
                end
                S_WRITE: begin
                    output_we <= 1'b0;
                    output_en <= 1'b0;
                    if (last_out) begin
                        done      <= 1'b1;
                        valid     <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        state_reg <= S_INIT;
                        if (int'(ox_reg) == OUT_W - 1) begin
                            ox_reg <= '0;
                            if (int'(oy_reg) == OUT_H - 1) begin
                                oy_reg <= '0;
                                oc_reg <= oc_reg + 1'b1;
                            end else begin
                                oy_reg <= oy_reg + 1'b1;
                            end
                        end else begin
                            ox_reg <= ox_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done      <= 1'b0;
                        valid     <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/conv_transpose2d.md
Name: conv_transpose2d

Overview:
- Transposed 2-D convolution (learned upsampling): the decoder-side counterpart of the stride-2 downsampling conv stage in the synthesis path.
- Reads a CHW int8 feature map from an external single-port input memory. Computes each output pixel by gathering its contributing input taps, one MAC per tap.
- Writes saturated int8 results to an external output memory.
- Uses the same start/done and memory-master interface style as the encoder conv stages, so the two can share buffer RAMs.

Parameters:
IN_CHANNELS, 2, input feature channels
OUT_CHANNELS, 2, output feature channels
IN_HEIGHT, 4, input rows
IN_WIDTH, 4, input columns
KERNEL_SIZE, 3, square kernel size
STRIDE, 2, upsampling stride
PADDING, 1, transposed-conv padding
OUTPUT_PADDING, 1, extra rows/cols appended bottom/right
DATA_WIDTH, 8, signed sample/weight width
ADDR_WIDTH, 8, memory address width
ACC_WIDTH, 20, signed accumulator width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  level request to begin one full pass
done  out  1  pass complete
valid  out  1  output memory contents valid (same timing as done)
input_addr  out  ADDR_WIDTH  input memory read address
input_en  out  1  input read strobe
input_data  in  DATA_WIDTH  signed read data, valid the cycle after input_en
output_addr  out  ADDR_WIDTH  output memory write address
output_data  out  DATA_WIDTH  signed write data
output_we  out  1  write enable
output_en  out  1  output memory enable

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - All outputs reset to 0; state goes to IDLE; all counters and accumulator cleared.
  - Internal weights[IC][OC][K][K] reset to +1; bias[OC] resets to 0.
  - Reset mid-pass aborts immediately. No further reads or writes are issued.
- Output dimensions:
  - OUT_H = (IN_HEIGHT-1)*STRIDE - 2*PADDING + KERNEL_SIZE + OUTPUT_PADDING. Defaults give 8.
  - OUT_W is computed the same way from IN_WIDTH. Defaults give 8.
- Tap rule for output (oy,ox) and kernel position (ky,kx):
  - ny = oy + PADDING - ky.
  - The tap is valid only if ny >= 0, ny % STRIDE == 0 and ny/STRIDE < IN_HEIGHT; iy = ny/STRIDE.
  - The same rule applies to x.
  - An invalid tap contributes 0.
- Addressing:
  - Input address = ic*IN_HEIGHT*IN_WIDTH + iy*IN_WIDTH + ix.
  - Output address = oc*OUT_H*OUT_W + oy*OUT_W + ox.
- Loop order, outermost first: oc, oy, ox, ic, ky, kx.
- FSM:
  - IDLE: wait for start=1, then clear oc/oy/ox and go to INIT. start is ignored in all other states.
  - INIT (1 cycle): acc <- sign-extended bias[oc]; clear ic/ky/kx; go to ISSUE.
  - ISSUE (1 cycle):
    - Valid tap: input_addr <- address, input_en <- 1.
    - Invalid tap: input_en <- 0, and a flag is recorded.
    - Go to ACC.
  - ACC (1 cycle):
    - input_en <- 0.
    - acc <- acc + (valid ? input_data*weight : 0), as a signed full-precision product.
    - Advance kx, then ky, then ic.
    - Go to ISSUE, or to STORE after the last tap.
  - STORE (1 cycle):
    - output_data <- acc saturated to [-128, 127]; output_addr <- address; output_we = output_en <- 1.
    - Go to WRITE.
  - WRITE (1 cycle):
    - output_we = output_en <- 0.
    - Advance ox, then oy, then oc, and go to INIT.
    - After the last output, go to DONE.
  - DONE: done = valid = 1, held while start=1. When start=0, clear both and return to IDLE.
- Latency is deterministic, with no early skip of invalid taps:
  - Per output pixel: 3 + 2*IN_CHANNELS*KERNEL_SIZE² cycles. Defaults give 39.
  - Full pass at defaults: 128 outputs * 39 = 4992 cycles from INIT entry to DONE entry.
- input_en and output_we are single-cycle pulses and are never high in the same cycle.
- Exactly one write per output address per pass.
- The accumulator never wraps for legal parameters: the ACC_WIDTH bound covers 128*128*IC*K² + bias.

Test Plan:
- Ramp check: start after reset with default params, inputs all 0x01. Required writes:
  - (oc0,0,0) = 2, (oc0,1,1) = 8, (oc0,2,2) = 2, (oc0,7,7) = 2, (oc1,1,1) at address 73 = 8.
  - Exactly 128 write pulses in total.
  - done rises 4992 cycles after INIT entry.
- Positive saturation: inputs all 0x7F. (0,1,1) has raw sum 1016, so it writes 0x7F. (0,0,0) has raw sum 254, so it writes 0x7F.
- Negative saturation: inputs all 0x80. (0,1,1) has raw sum -1024, so it writes 0x80. (0,0,0) has raw sum -256, so it writes 0x80.
- Padding and gather addressing: input channel 0 all 0, channel 1 at (iy,ix) holds iy*4+ix+1. Required writes:
  - (0,1,1) = 1+2+5+6 = 14.
  - (0,7,7) = 16.
  - No input_en is ever issued with an address ≥ 32.
  - Every read address matches the tap rule.
- Handshake: hold start high through the pass. done and valid must stay 1 until start drops, then clear the next cycle. Pulsing start mid-pass has no effect.
- Reset mid-op: assert rst for 1 cycle at cycle 500. All outputs are 0 the next cycle, with no further reads or writes. A fresh start then reproduces the ramp results exactly.
